// File: rtl/riscv_lsu.sv
// Load/store unit: sequences core data accesses onto a req/ready bus.
// Define RISCV_LSU_MISALIGN_EN to trap misaligned H/W accesses.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] raw_q, raw_d;

    logic        src_we;
    logic [2:0]  src_size;
    logic [31:0] src_addr;
    logic [31:0] src_wd;
    logic        src_b, src_h, src_w;
    logic        bus_req;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        mis_req;
    logic        mis_hit;

    // IDLE forwards the core request directly so zero-wait buses finish in one cycle
    always_comb begin
        src_we   = we_q;
        src_size = size_q;
        src_addr = addr_q;
        src_wd   = wd_q;
        if (state_q == IDLE) begin
            src_we   = core_we_i;
            src_size = core_size_i;
            src_addr = core_addr_i;
            src_wd   = core_wd_i;
        end
    end

    assign src_b = (src_size[1:0] == 2'b00);
    assign src_h = (src_size[1:0] == 2'b01);
    assign src_w = !src_b && !src_h;

    always_comb begin
        mem_be_o = 4'b1111;
        mem_wd_o = src_wd;
        unique case (1'b1)
            src_b: begin
                mem_be_o = 4'b0001 << src_addr[1:0];
                mem_wd_o = {4{src_wd[7:0]}};
            end
            src_h: begin
                mem_be_o = src_addr[1] ? 4'b1100 : 4'b0011;
                mem_wd_o = {2{src_wd[15:0]}};
            end
            src_w: mem_be_o = 4'b1111;
        endcase
    end

    assign mem_addr_o = {src_addr[31:2], 2'b00};
    assign mem_req_o  = bus_req;
    assign mem_we_o   = bus_req & src_we;

`ifdef RISCV_LSU_MISALIGN_EN
    logic mis_q, mis_d;

    assign mis_req = core_req_i &
                     ((src_h & src_addr[0]) |
                      (src_w & (src_addr[1:0] != 2'b00)));
    assign mis_hit    = mis_q;
    assign misalign_o = (state_q == DONE) & mis_q;

    always_comb begin
        mis_d = mis_q;
        if (state_q == IDLE && core_req_i) begin
            mis_d = mis_req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`else
    assign mis_req    = 1'b0;
    assign mis_hit    = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = raw_q[7:0];
            2'd1:    ld_byte = raw_q[15:8];
            2'd2:    ld_byte = raw_q[23:16];
            default: ld_byte = raw_q[31:24];
        endcase
        ld_half = addr_q[1] ? raw_q[31:16] : raw_q[15:0];
        ld_data = raw_q;
        if (size_q[1:0] == 2'b00) begin
            ld_data = size_q[2] ? {24'd0, ld_byte}
                                : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_q[1:0] == 2'b01) begin
            ld_data = size_q[2] ? {16'd0, ld_half}
                                : {{16{ld_half[15]}}, ld_half};
        end
    end

    assign core_rd_o = (state_q == DONE && !mis_hit) ? ld_data : 32'd0;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        raw_d        = raw_q;
        bus_req      = 1'b0;
        core_stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus_req      = core_req_i & !mis_req;
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    addr_d = core_addr_i;
                    wd_d   = core_wd_i;
                    if (mis_req) begin
                        state_d = DONE;
                    end else if (mem_ready_i) begin
                        raw_d   = mem_rd_i;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                bus_req      = 1'b1;
                core_stall_o = core_req_i;
                // a trapped core drops its request; finish the bus beat then drop the data
                if (mem_ready_i) begin
                    if (core_req_i) begin
                        raw_d   = mem_rd_i;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            raw_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            raw_q   <= raw_d;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu.
// Honours RISCV_LSU_MISALIGN_EN for the misaligned-access case.
module tb_riscv_lsu;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_lsu dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready),
        .misalign_o   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we,
                         input logic [2:0] size,
                         input logic [31:0] addr,
                         input logic [31:0] wd);
        core_req  = req;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
    endtask

    initial begin
        rst       = 1'b1;
        mem_rd    = 32'd0;
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("rst_rd", core_rd, 32'd0);
        check("rst_mis", {31'd0, misalign}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, core_stall}, 32'd0);
        core_req = 1'b1;
        #1;
        check("rst_req_follow", {31'd0, mem_req}, 32'd1);
        check("rst_stall_follow", {31'd0, core_stall}, 32'd1);
        core_req = 1'b0;

        // LW zero wait
        tick;
        drive(1'b1, 1'b0, 3'd2, 32'h104, 32'd0);
        mem_ready = 1'b1;
        mem_rd    = 32'hDEADBEEF;
        #1;
        check("lw_addr", mem_addr, 32'h104);
        check("lw_be", {28'd0, mem_be}, 32'hF);
        check("lw_stall0", {31'd0, core_stall}, 32'd1);
        check("lw_we", {31'd0, mem_we}, 32'd0);
        tick;
        // DONE; present LB back-to-back
        drive(1'b1, 1'b0, 3'd0, 32'h203, 32'd0);
        mem_rd = 32'h80FF_0000;
        #1;
        check("lw_stall1", {31'd0, core_stall}, 32'd0);
        check("lw_done_req", {31'd0, mem_req}, 32'd0);
        check("lw_rd", core_rd, 32'hDEADBEEF);
        tick;
        check("lb_idle_rd", core_rd, 32'd0);
        check("lb_be", {28'd0, mem_be}, 32'h8);
        check("lb_addr", mem_addr, 32'h200);
        tick;
        check("lb_rd", core_rd, 32'hFFFFFF80);
        drive(1'b1, 1'b0, 3'd4, 32'h203, 32'd0);
        tick;
        tick;
        check("lbu_rd", core_rd, 32'h00000080);

        // LH / LHU upper half
        drive(1'b1, 1'b0, 3'd1, 32'h102, 32'd0);
        mem_rd = 32'h8001_7FFF;
        tick;
        check("lh_be", {28'd0, mem_be}, 32'hC);
        tick;
        check("lh_rd", core_rd, 32'hFFFF8001);
        drive(1'b1, 1'b0, 3'd5, 32'h100, 32'd0);
        tick;
        tick;
        check("lhu_rd", core_rd, 32'h00007FFF);

        // SB zero wait
        drive(1'b1, 1'b1, 3'd0, 32'h201, 32'h0000005A);
        tick;
        check("sb_be", {28'd0, mem_be}, 32'h2);
        check("sb_wd", mem_wd, 32'h5A5A5A5A);
        check("sb_we", {31'd0, mem_we}, 32'd1);
        tick;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        mem_ready = 1'b0;
        mem_rd    = 32'd0;

        // SH with 3 wait states
        tick;
        drive(1'b1, 1'b1, 3'd1, 32'h12, 32'h0000ABCD);
        #1;
        check("sh_addr", mem_addr, 32'h10);
        check("sh_be", {28'd0, mem_be}, 32'hC);
        check("sh_wd", mem_wd, 32'hABCDABCD);
        check("sh_stall_c0", {31'd0, core_stall}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick;
            core_wd   = 32'h1111_2222;
            core_addr = 32'h0;
            mem_ready = (i == 3);
            #1;
            check("sh_busy_req", {31'd0, mem_req}, 32'd1);
            check("sh_busy_we", {31'd0, mem_we}, 32'd1);
            check("sh_busy_addr", mem_addr, 32'h10);
            check("sh_busy_be", {28'd0, mem_be}, 32'hC);
            check("sh_busy_wd", mem_wd, 32'hABCDABCD);
            check("sh_busy_stall", {31'd0, core_stall}, 32'd1);
        end
        tick;
        mem_ready = 1'b0;
        core_req  = 1'b0;
        #1;
        check("sh_done_stall", {31'd0, core_stall}, 32'd0);
        check("sh_done_req", {31'd0, mem_req}, 32'd0);

        // trap mid-access
        tick;
        drive(1'b1, 1'b0, 3'd2, 32'h40, 32'd0);
        mem_rd = 32'h1234_5678;
        tick;
        core_req = 1'b0;
        #1;
        check("trap_req_held", {31'd0, mem_req}, 32'd1);
        check("trap_stall", {31'd0, core_stall}, 32'd0);
        tick;
        check("trap_req_held2", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        #1;
        check("trap_idle_req", {31'd0, mem_req}, 32'd0);
        check("trap_rd", core_rd, 32'd0);
        tick;
        check("trap_rd2", core_rd, 32'd0);

        // reset in BUSY
        drive(1'b1, 1'b0, 3'd2, 32'h80, 32'd0);
        tick;
        check("rb_busy_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick;
        rst       = 1'b0;
        core_addr = 32'h300;
        #1;
        check("rb_rd", core_rd, 32'd0);
        check("rb_addr", mem_addr, 32'h300);
        core_req = 1'b0;
        #1;
        check("rb_req_follow", {31'd0, mem_req}, 32'd0);

        // misaligned LW at 0x102
        tick;
        drive(1'b1, 1'b0, 3'd2, 32'h102, 32'd0);
        mem_ready = 1'b1;
        mem_rd    = 32'hCAFE_F00D;
        #1;
`ifdef RISCV_LSU_MISALIGN_EN
        check("mis_req", {31'd0, mem_req}, 32'd0);
        check("mis_stall", {31'd0, core_stall}, 32'd1);
        tick;
        mem_ready = 1'b0;
        core_req  = 1'b0;
        #1;
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        check("mis_rd", core_rd, 32'd0);
        check("mis_done_req", {31'd0, mem_req}, 32'd0);
        tick;
        check("mis_pulse_end", {31'd0, misalign}, 32'd0);
`else
        check("mis_req", {31'd0, mem_req}, 32'd1);
        check("mis_addr", mem_addr, 32'h100);
        check("mis_be", {28'd0, mem_be}, 32'hF);
        tick;
        mem_ready = 1'b0;
        core_req  = 1'b0;
        #1;
        check("mis_flag", {31'd0, misalign}, 32'd0);
        check("mis_rd", core_rd, 32'hCAFEF00D);
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
